ram_arb4: RTL
=============

RAM_ARB4 -- requirements
Module: ram_arb4

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 9, RAM word width.
REQ-002 SHALL have parameter ADDRWIDTH, default 9, RAM address width; depth = 2^ADDRWIDTH.
REQ-003 SHALL have parameter RD_LAT, default 2, cycles from mem_addr registered to mem_rd_data valid.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset_l  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  4  per-requester access request, bit i = requester i.
REQ-007 SHALL have port we  input  4  per-requester write flag; 1 = write, 0 = read.
REQ-008 SHALL have port addr  input  4*ADDRWIDTH  per-requester address, requester i at [i*ADDRWIDTH +: ADDRWIDTH].
REQ-009 SHALL have port wr_data  input  4*DATAWIDTH  per-requester write data, same packing.
REQ-010 SHALL have port gnt  output  4  one-hot-or-zero grant; request accepted at the clock edge ending a cycle with gnt[i]=1.
REQ-011 SHALL have port mem_addr  output  ADDRWIDTH  registered address to one port of the dual-address RAM.
REQ-012 SHALL have port mem_wr_data  output  DATAWIDTH  registered write data to RAM.
REQ-013 SHALL have port mem_we  output  1  registered write enable to RAM.
REQ-014 SHALL have port mem_rd_data  input  DATAWIDTH  RAM read data.
REQ-015 SHALL have port rd_valid  output  1  read return strobe, one cycle per accepted read.
REQ-016 SHALL have port rd_id  output  2  requester index owning the current rd_valid.
REQ-017 SHALL have port rd_data  output  DATAWIDTH  read return data, equal to mem_rd_data.
REQ-018 SHALL have port init_done  output  1  high once RAM clear is complete.

Function
REQ-019 SHALL implement states INIT and RUN; reset enters INIT.
REQ-020 SHALL, in INIT, drive mem_we=1, mem_wr_data=0, mem_addr counting 0 to 2^ADDRWIDTH-1, one address per cycle.
REQ-021 SHALL transition INIT->RUN in the cycle after address 2^ADDRWIDTH-1 is written, asserting init_done from then until reset.
REQ-022 SHALL hold gnt=0 throughout INIT regardless of req.
REQ-023 SHALL, in RUN, compute gnt combinationally: first i with req[i]=1 searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-024 SHALL update ptr to (granted index + 1) mod 4 on each grant; ptr unchanged when no grant; ptr reset value 0.
REQ-025 SHALL register the granted requester's addr, wr_data, we onto mem_addr, mem_wr_data, mem_we at the granting edge (one-cycle latency).
REQ-026 SHALL drive mem_we=0 in RUN cycles following a no-grant cycle; mem_addr/mem_wr_data hold previous values.
REQ-027 SHALL, for a read granted in cycle N, assert rd_valid=1 with rd_id=i in cycle N+1+RD_LAT, via an RD_LAT+1-deep valid/id shift pipeline.
REQ-028 SHALL sustain one grant per cycle; back-to-back reads return back-to-back in grant order.
REQ-029 SHALL generate no rd_valid for writes.
REQ-030 Requesters SHALL hold req, we, addr, wr_data stable until granted; dropping req before grant is legal and withdraws the request.
REQ-031 SHALL return old data for a read granted the cycle after a write to the same address only per RAM semantics; no forwarding is performed.

Reset
REQ-032 SHALL, on reset_l low, asynchronously clear: state=INIT, init counter=0, ptr=0, mem_we=0, mem_addr=0, mem_wr_data=0, rd_valid pipeline=0, rd_id=0, init_done=0, gnt=0.
REQ-033 SHALL, on reset asserted mid-INIT or mid-RUN, discard pending read returns and restart INIT from address 0 after release.

Verification
REQ-034 Reset release, ADDRWIDTH=4 -> mem_we=1, mem_wr_data=0 for 16 cycles, mem_addr 0..15, then init_done=1, mem_we=0.
REQ-035 req=4'b1111 continuous in RUN, ptr=0 -> gnt sequence 0001,0010,0100,1000,0001.
REQ-036 Requester 2 writes 0x1A5 to addr 7, then requester 0 reads addr 7 -> rd_valid one cycle, rd_id=0, rd_data=0x1A5, 3 cycles after read grant.
REQ-037 Reads from requesters 1,3,1 granted consecutively -> rd_valid high 3 consecutive cycles, rd_id 1,3,1.
REQ-038 req asserted during INIT -> gnt=0 until init_done=1; first RUN cycle grants lowest index at/after ptr=0.
REQ-039 reset_l pulsed low while a read is in flight -> no rd_valid after release; INIT restarts at address 0.

Source files
------------

// File: rtl/ram_arb4.sv
// ram_arb4: four-requester round-robin arbiter in front of one port of a RAM.
// After reset the RAM is cleared by a linear write sweep (INIT); after that, requests are
// granted one per cycle in round-robin order and forwarded to the RAM through registers.
// Read returns are tagged with the requester index via a valid/id delay line that matches
// the RAM read latency.
//
// Ports:
//   clk          sole clock, posedge
//   reset_l      asynchronous active-low reset
//   req[3:0]     per-requester request
//   we[3:0]      per-requester write flag (1 = write, 0 = read)
//   addr         packed per-requester addresses, requester i at [i*ADDRWIDTH +: ADDRWIDTH]
//   wr_data      packed per-requester write data, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   gnt[3:0]     one-hot-or-zero combinational grant
//   mem_addr     registered RAM address
//   mem_wr_data  registered RAM write data
//   mem_we       registered RAM write enable
//   mem_rd_data  RAM read data, valid RD_LAT cycles after mem_addr is registered
//   rd_valid     read return strobe
//   rd_id        requester index owning rd_valid
//   rd_data      read return data (mem_rd_data passed through)
//   init_done    high once the RAM clear sweep has finished
module ram_arb4 #(
  parameter int unsigned DATAWIDTH = 9,
  parameter int unsigned ADDRWIDTH = 9,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic [3:0]             req,
  input  logic [3:0]             we,
  input  logic [4*ADDRWIDTH-1:0] addr,
  input  logic [4*DATAWIDTH-1:0] wr_data,
  output logic [3:0]             gnt,
  output logic [ADDRWIDTH-1:0]   mem_addr,
  output logic [DATAWIDTH-1:0]   mem_wr_data,
  output logic                   mem_we,
  input  logic [DATAWIDTH-1:0]   mem_rd_data,
  output logic                   rd_valid,
  output logic [1:0]             rd_id,
  output logic [DATAWIDTH-1:0]   rd_data,
  output logic                   init_done
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                 state_q, state_d;
  // One bit wider than the address: the MSB sets once every address has been issued.
  logic [ADDRWIDTH:0]     init_cnt_q, init_cnt_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [ADDRWIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATAWIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic                   mem_we_q, mem_we_d;
  logic                   init_done_q, init_done_d;
  logic [RD_LAT:0]        vld_q, vld_d;
  logic [RD_LAT:0][1:0]   id_q, id_d;

  logic                   gnt_any;
  logic [1:0]             gnt_idx;
  logic [1:0]             cand;
  logic                   rd_grant;
  logic [ADDRWIDTH-1:0]   addr_arr [4];
  logic [DATAWIDTH-1:0]   data_arr [4];

  // Unpack the per-requester buses so the granted one can be picked by index.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr_arr[i] = addr[i*ADDRWIDTH +: ADDRWIDTH];
      data_arr[i] = wr_data[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Round-robin search starting at ptr; nothing is granted while the RAM is being cleared.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    if (state_q == StRun) begin
      for (int k = 0; k < 4; k++) begin
        cand = ptr_q + 2'(k);
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    gnt = 4'b0000;
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign rd_grant = gnt_any && !we[gnt_idx];

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    ptr_d         = ptr_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_we_d      = 1'b0;
    init_done_d   = init_done_q;
    unique case (state_q)
      StInit: begin
        if (init_cnt_q[ADDRWIDTH]) begin
          // Last clear write is being presented now; RUN starts with mem_we low.
          state_d     = StRun;
          init_done_d = 1'b1;
        end else begin
          mem_addr_d    = init_cnt_q[ADDRWIDTH-1:0];
          mem_wr_data_d = '0;
          mem_we_d      = 1'b1;
          init_cnt_d    = init_cnt_q + {{ADDRWIDTH{1'b0}}, 1'b1};
        end
      end
      StRun: begin
        if (gnt_any) begin
          mem_addr_d    = addr_arr[gnt_idx];
          mem_wr_data_d = data_arr[gnt_idx];
          mem_we_d      = we[gnt_idx];
          ptr_d         = gnt_idx + 2'd1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Read-return delay line: stage 0 loads at the granting edge, stage RD_LAT lines up
  // with mem_rd_data.
  always_comb begin
    vld_d    = vld_q;
    id_d     = id_q;
    vld_d[0] = rd_grant;
    id_d[0]  = gnt_idx;
    for (int unsigned k = 1; k <= RD_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      id_d[k]  = id_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= StInit;
      init_cnt_q    <= '0;
      ptr_q         <= 2'd0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_we_q      <= 1'b0;
      init_done_q   <= 1'b0;
      vld_q         <= '0;
      id_q          <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      ptr_q         <= ptr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_we_q      <= mem_we_d;
      init_done_q   <= init_done_d;
      vld_q         <= vld_d;
      id_q          <= id_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_we      = mem_we_q;
  assign init_done   = init_done_q;
  assign rd_valid    = vld_q[RD_LAT];
  assign rd_id       = id_q[RD_LAT];
  assign rd_data     = mem_rd_data;

endmodule
